// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage types and constants
package fetch_pkg;

  typedef logic [31:0] addr_t;

  localparam addr_t INSN_BYTES       = 32'd4;
  localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return address stack with saturating occupancy count
module ras_stack
  import fetch_pkg::*;
#(
  parameter int RAS_DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  addr_t push_addr,
  output addr_t top,
  output logic  empty,
  output logic  full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  addr_t          mem_q [RAS_DEPTH];
  logic [PW-1:0]  sp_q, sp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           wr_en;
  logic [PW-1:0]  wr_idx;

  assign top   = mem_q[sp_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(RAS_DEPTH));

  always_comb begin
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = sp_q;
    if (push && pop && !empty) begin
      wr_en = 1'b1;
    end else if (push) begin
      // Advancing past a full stack lands on the oldest entry and overwrites it.
      sp_d   = sp_q + 1'b1;
      wr_idx = sp_q + 1'b1;
      wr_en  = 1'b1;
      if (!full) cnt_d = cnt_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d  = sp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_addr;
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - N-issue fetch PC generator; return address stack built when FETCH_RAS_EN is defined
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int    ISSUE_W   = 2,
  parameter addr_t RESET_PC  = RESET_PC_DEFAULT,
  parameter int    RAS_DEPTH = 8
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            stall,
  input  logic                                            flush,
  input  logic [((ISSUE_W > 1) ? $clog2(ISSUE_W) : 1)-1:0] flush_slot,
  input  logic [ISSUE_W*32-1:0]                           flush_tgt,
  input  logic [$clog2(ISSUE_W+1)-1:0]                    issue_cnt,
  input  logic [ISSUE_W-1:0]                              br_taken,
  input  logic [ISSUE_W*32-1:0]                           br_off,
  input  logic                                            ras_push,
  input  addr_t                                           ras_push_addr,
  input  logic                                            ras_pop,
  output addr_t                                           pc,
  output addr_t                                           npc,
  output logic                                            ras_empty,
  output logic                                            ras_full
);

  localparam int FSW = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;

  addr_t pc_q;
  addr_t flush_sel;
  addr_t br_pc;
  addr_t seq_pc;
  addr_t ras_top;
  logic  br_hit;
  logic  ras_hit;

  assign pc     = pc_q;
  assign seq_pc = pc_q + addr_t'(issue_cnt) * INSN_BYTES;

  always_comb begin
    flush_sel = flush_tgt[31:0];
    for (int k = 0; k < ISSUE_W; k++) begin
      if (FSW'(k) == flush_slot) flush_sel = flush_tgt[32*k +: 32];
    end
  end

  // Scan from the top slot down so the lowest taken, issued slot wins.
  always_comb begin
    br_hit = 1'b0;
    br_pc  = seq_pc;
    for (int k = ISSUE_W - 1; k >= 0; k--) begin
      if (br_taken[k] && (k < int'(issue_cnt))) begin
        br_hit = 1'b1;
        br_pc  = pc_q + addr_t'(k) * INSN_BYTES + br_off[32*k +: 32];
      end
    end
  end

`ifdef FETCH_RAS_EN
  logic ras_upd;

  assign ras_upd = !stall && !flush;

  ras_stack #(
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (ras_push && ras_upd),
    .pop      (ras_pop && ras_upd),
    .push_addr(ras_push_addr),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  assign ras_hit = ras_pop && !ras_empty;
`else
  logic unused_ras;

  assign unused_ras = ^{ras_push, ras_pop, ras_push_addr};
  assign ras_top    = pc_q;
  assign ras_hit    = 1'b0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
`endif

  always_comb begin
    npc = seq_pc;
    if (flush)        npc = flush_sel;
    else if (stall)   npc = pc_q;
    else if (ras_hit) npc = ras_top;
    else if (br_hit)  npc = br_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= npc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(issue_cnt) <= ISSUE_W);
      assert (!flush || (int'(flush_slot) < ISSUE_W));
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - self-checking bench for fetch_pc_gen against a queue-based reference model
module tb_fetch_pc_gen;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [0:0]  flush_slot = '0;
  logic [63:0] flush_tgt = '0;
  logic [1:0]  issue_cnt = '0;
  logic [1:0]  br_taken = '0;
  logic [63:0] br_off = '0;
  logic        ras_push = 1'b0;
  logic [31:0] ras_push_addr = '0;
  logic        ras_pop = 1'b0;
  logic [31:0] pc, npc;
  logic        ras_empty, ras_full;

  int total = 0;
  int bad = 0;

  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ras [$];

  fetch_pc_gen #(.ISSUE_W(2), .RESET_PC(32'h0), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_slot(flush_slot),
    .flush_tgt(flush_tgt), .issue_cnt(issue_cnt), .br_taken(br_taken), .br_off(br_off),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .pc(pc), .npc(npc), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_npc();
    if (flush) return flush_tgt[32*flush_slot +: 32];
    if (stall) return m_pc;
`ifdef FETCH_RAS_EN
    if (ras_pop && m_ras.size() > 0) return m_ras[$];
`endif
    for (int k = 0; k < int'(issue_cnt); k++)
      if (br_taken[k]) return m_pc + 32'(4 * k) + br_off[32*k +: 32];
    return m_pc + 32'(4 * int'(issue_cnt));
  endfunction

  task automatic tick();
    logic [31:0] n;
    n = model_npc();
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0;
      m_ras.delete();
    end else begin
      m_pc = n;
`ifdef FETCH_RAS_EN
      if (!stall && !flush) begin
        if (ras_push && ras_pop && m_ras.size() > 0) m_ras[m_ras.size()-1] = ras_push_addr;
        else if (ras_push) begin
          m_ras.push_back(ras_push_addr);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (ras_pop && m_ras.size() > 0) void'(m_ras.pop_back());
      end
`endif
    end
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    flush = 1'b1; flush_slot = 1'b0; flush_tgt = {32'h0, tgt};
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total += 3;
    if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    if (ras_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", ras_empty); end
    if (ras_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", ras_full); end
  endtask

  task automatic test_sequential();
    logic [1:0]  cnts [4] = '{2'd2, 2'd2, 2'd1, 2'd0};
    logic [31:0] exps [4] = '{32'h8, 32'h10, 32'h14, 32'h14};
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_cnt = cnts[i];
      tick();
      total++;
      if (pc !== exps[i]) begin bad++; $display("FAIL seq_%0d got=%h exp=%h", i, pc, exps[i]); end
    end
  endtask

  task automatic test_branch();
    logic [1:0]  tk   [3] = '{2'b10, 2'b11, 2'b10};
    logic [1:0]  cnts [3] = '{2'd2, 2'd2, 2'd1};
    logic [31:0] exps [3] = '{32'h124, 32'h140, 32'h104};
    for (int i = 0; i < 3; i++) begin
      issue_cnt = 2'd0; br_taken = 2'b00;
      redirect(32'h100);
      issue_cnt = cnts[i]; br_taken = tk[i]; br_off = {32'h20, 32'h40};
      tick();
      total++;
      if (pc !== exps[i]) begin bad++; $display("FAIL branch_%0d got=%h exp=%h", i, pc, exps[i]); end
    end
    br_taken = 2'b00; issue_cnt = 2'd0;
  endtask

  task automatic test_flush_priority();
    stall = 1'b1; flush = 1'b1; flush_slot = 1'b1; flush_tgt = {32'h800, 32'h400};
    issue_cnt = 2'd2;
    tick();
    flush = 1'b0;
    total++;
    if (pc !== 32'h800) begin bad++; $display("FAIL flush_over_stall got=%h exp=%h", pc, 32'h800); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (pc !== 32'h800) begin bad++; $display("FAIL stall_hold_%0d got=%h exp=%h", i, pc, 32'h800); end
    end
    stall = 1'b0; issue_cnt = 2'd0;
  endtask

`ifdef FETCH_RAS_EN
  task automatic test_ras_order();
    logic [31:0] exps [2] = '{32'h304, 32'h204};
    ras_push = 1'b1; ras_push_addr = 32'h204; tick();
    ras_push_addr = 32'h304; tick();
    ras_push = 1'b0; ras_pop = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (pc !== exps[i]) begin bad++; $display("FAIL ras_pop_%0d got=%h exp=%h", i, pc, exps[i]); end
    end
    ras_pop = 1'b0;
    redirect(32'h200);
    ras_pop = 1'b1; issue_cnt = 2'd2;
    tick();
    ras_pop = 1'b0; issue_cnt = 2'd0;
    total += 2;
    if (pc !== 32'h208) begin bad++; $display("FAIL ras_pop_empty got=%h exp=%h", pc, 32'h208); end
    if (ras_empty !== 1'b1) begin bad++; $display("FAIL ras_order_empty got=%b exp=1", ras_empty); end
  endtask

  task automatic test_ras_overflow();
    ras_push = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      ras_push_addr = 32'h1000 + 32'(i * 16);
      tick();
    end
    ras_push = 1'b0;
    total++;
    if (ras_full !== 1'b1) begin bad++; $display("FAIL ras_full got=%b exp=1", ras_full); end
    ras_pop = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      total++;
      if (pc !== 32'h1000 + 32'((5 - j) * 16)) begin
        bad++; $display("FAIL ras_ovf_pop_%0d got=%h exp=%h", j, pc, 32'h1000 + 32'((5 - j) * 16));
      end
    end
    ras_pop = 1'b0;
    total++;
    if (ras_empty !== 1'b1) begin bad++; $display("FAIL ras_ovf_empty got=%b exp=1", ras_empty); end
    ras_push = 1'b1; ras_push_addr = 32'h50; tick();
    ras_pop = 1'b1; ras_push_addr = 32'h60;
    #1;
    total++;
    if (npc !== 32'h50) begin bad++; $display("FAIL ras_pushpop_npc got=%h exp=%h", npc, 32'h50); end
    tick();
    total += 2;
    if (pc !== 32'h50) begin bad++; $display("FAIL ras_pushpop_pc got=%h exp=%h", pc, 32'h50); end
    if (ras_empty !== 1'b0) begin bad++; $display("FAIL ras_pushpop_cnt got=%b exp=0", ras_empty); end
    ras_push = 1'b0;
    tick();
    ras_pop = 1'b0;
    total += 2;
    if (pc !== 32'h60) begin bad++; $display("FAIL ras_replaced_top got=%h exp=%h", pc, 32'h60); end
    if (ras_empty !== 1'b1) begin bad++; $display("FAIL ras_final_empty got=%b exp=1", ras_empty); end
  endtask
`else
  task automatic test_macro_off();
    redirect(32'h300);
    ras_push = 1'b1; ras_push_addr = 32'h900; tick();
    ras_push = 1'b0; ras_pop = 1'b1; issue_cnt = 2'd2; tick();
    ras_pop = 1'b0; issue_cnt = 2'd0;
    total += 3;
    if (pc !== 32'h308) begin bad++; $display("FAIL noras_pc got=%h exp=%h", pc, 32'h308); end
    if (ras_empty !== 1'b1) begin bad++; $display("FAIL noras_empty got=%b exp=1", ras_empty); end
    if (ras_full !== 1'b0) begin bad++; $display("FAIL noras_full got=%b exp=0", ras_full); end
  endtask
`endif

  task automatic test_random();
    logic exp_empty, exp_full;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      flush_slot = 1'($urandom_range(0, 1));
      flush_tgt = {$urandom(), $urandom()};
      issue_cnt = 2'($urandom_range(0, 2));
      br_taken = 2'($urandom_range(0, 3));
      br_off = {$urandom(), $urandom()};
      ras_push = ($urandom_range(0, 3) == 0);
      ras_pop = ($urandom_range(0, 3) == 0);
      ras_push_addr = $urandom();
      #1;
      total++;
      if (!rst && npc !== model_npc()) begin
        bad++; $display("FAIL rand_npc_%0d got=%h exp=%h", i, npc, model_npc());
      end
      tick();
      exp_empty = (m_ras.size() == 0);
      exp_full = (m_ras.size() == DEPTH);
      total += 3;
      if (pc !== m_pc) begin bad++; $display("FAIL rand_pc_%0d got=%h exp=%h", i, pc, m_pc); end
      if (ras_empty !== exp_empty) begin bad++; $display("FAIL rand_empty_%0d got=%b exp=%b", i, ras_empty, exp_empty); end
      if (ras_full !== exp_full) begin bad++; $display("FAIL rand_full_%0d got=%b exp=%b", i, ras_full, exp_full); end
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_sequential();
    test_branch();
    test_flush_priority();
`ifdef FETCH_RAS_EN
    test_ras_order();
    test_ras_overflow();
`else
    test_macro_off();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
